// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-channel mux select arbiter.
package mux_arb_pkg;

  localparam int CH_NUM = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

  // Round-robin pick: a lone request wins outright; on a tie the channel not served last wins.
  function automatic logic rr_pick(input logic [CH_NUM-1:0] pend_eff, input logic lp);
    logic pick;
    case (pend_eff)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~lp;
      default: pick = lp;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mux_arb_timer.sv
// Loadable down-counter with zero flag; times both the settle and the valid window.
module mux_arb_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 2:1 mux with settle/valid/ack sequencing.
// Optional drop counters are built when MUX_SEL_DROP_CNT_EN is defined.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 4
`ifdef MUX_SEL_DROP_CNT_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] req,
  output logic              sel,
  output logic              busy,
  output logic              out_valid,
  output logic [CH_NUM-1:0] ack
`ifdef MUX_SEL_DROP_CNT_EN
  , output logic [CNT_W-1:0] drop_cnt0
  , output logic [CNT_W-1:0] drop_cnt1
`endif
);

  localparam int MAX_CYC = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  generate
    if (SETTLE_CYC < 1 || HOLD_CYC < 1) begin : g_param_err
      $error("mux_sel_arbiter: SETTLE_CYC and HOLD_CYC must both be >= 1");
    end
  endgenerate

  arb_state_t        r_state, w_state_next;
  logic              r_sel, w_sel_next;
  logic              r_lp, w_lp_next;
  logic              r_busy, r_out_valid;
  logic [CH_NUM-1:0] r_ack;
  logic [CH_NUM-1:0] r_pend, w_pend_eff, w_pend_next, w_clr;
  logic              w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [TW-1:0]     w_tmr_load_val;

  assign w_pend_eff = r_pend | req;

  mux_arb_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_lp_next      = r_lp;
    w_clr          = '0;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend_eff != '0) begin
          w_sel_next     = rr_pick(w_pend_eff, r_lp);
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TW'(SETTLE_CYC - 1);
          w_state_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (w_tmr_zero) begin
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TW'(HOLD_CYC - 1);
          w_state_next   = VALID;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      VALID: begin
        if (w_tmr_zero) begin
          w_state_next = ACK;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ACK: begin
        w_clr        = r_sel ? 2'b10 : 2'b01;
        w_lp_next    = r_sel;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A request arriving in the clearing cycle re-arms the flag, so set wins over clear.
  assign w_pend_next = (r_pend & ~w_clr) | req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_lp        <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_ack       <= '0;
      r_pend      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_lp        <= w_lp_next;
      r_busy      <= (w_state_next != IDLE);
      r_out_valid <= (w_state_next == VALID);
      r_ack       <= (w_state_next == ACK) ? (w_sel_next ? 2'b10 : 2'b01) : 2'b00;
      r_pend      <= w_pend_next;
    end
  end

  assign sel       = r_sel;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign ack       = r_ack;

`ifdef MUX_SEL_DROP_CNT_EN
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_drop
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (req[gi] && r_pend[gi] && !w_clr[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign drop_cnt0 = g_drop[0].r_cnt;
  assign drop_cnt1 = g_drop[1].r_cnt;
`endif

endmodule
